// File: rtl/mem_bus_ctrl_if.sv
// ============================================================================
// mem_bus_ctrl_if : MEM-stage request, load response and data-bus signals
// Revision 1.0
// ============================================================================
`default_nettype none

interface mem_bus_ctrl_if;
    logic        req_valid;
    logic        req_ren;
    logic [3:0]  req_wen;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        addr_err;

    modport master (
        input  req_valid, req_ren, req_wen, req_size, req_addr, req_wdata, flush,
        input  data_addr_ok, data_data_ok, data_rdata,
        output stall, resp_valid, resp_rdata, addr_err,
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb
    );

    modport slave (
        output req_valid, req_ren, req_wen, req_size, req_addr, req_wdata, flush,
        output data_addr_ok, data_data_ok, data_rdata,
        input  stall, resp_valid, resp_rdata, addr_err,
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
// ============================================================================
// mem_bus_ctrl : single-outstanding MEM-stage load/store bus controller
// Optional misalignment trap: define MEM_ALIGN_CHECK_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_bus_ctrl (
    input  wire logic      clk,
    input  wire logic      resetn,
    mem_bus_ctrl_if.master mbus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic        discard_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        data_req_q;
    logic        data_wr_q;
    logic [1:0]  data_size_q;
    logic [31:0] data_addr_q;
    logic [31:0] data_wdata_q;
    logic [3:0]  data_wstrb_q;

    logic w_is_store;
    logic w_op;
    logic w_misalign;

    assign w_is_store = (mbus.req_wen != 4'b0000);
    assign w_op       = mbus.req_valid && (w_is_store || mbus.req_ren);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ((mbus.req_size == 2'd1) && mbus.req_addr[0]) ||
                        ((mbus.req_size == 2'd2) && (mbus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            discard_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            data_req_q   <= 1'b0;
            data_wr_q    <= 1'b0;
            data_size_q  <= 2'b00;
            data_addr_q  <= 32'h0;
            data_wdata_q <= 32'h0;
            data_wstrb_q <= 4'b0000;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_op && !mbus.flush && !w_misalign) begin
                        data_req_q   <= 1'b1;
                        data_wr_q    <= w_is_store;
                        data_size_q  <= mbus.req_size;
                        data_addr_q  <= mbus.req_addr;
                        data_wdata_q <= mbus.req_wdata;
                        data_wstrb_q <= w_is_store ? mbus.req_wen : 4'b0000;
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A data_ok seen alongside addr_ok belongs to no accepted
                    // request yet, so only the address handshake counts here.
                    if (mbus.data_addr_ok) begin
                        data_req_q <= 1'b0;
                        discard_q  <= mbus.flush;
                        state_q    <= S_WAIT;
                    end else if (mbus.flush) begin
                        data_req_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (mbus.data_data_ok) begin
                        if (discard_q || mbus.flush) begin
                            discard_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            resp_rdata_q <= mbus.data_rdata;
                            resp_valid_q <= !data_wr_q;
                            state_q      <= S_DONE;
                        end
                    end else if (mbus.flush) begin
                        discard_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // A discarded transfer no longer belongs to the pipeline, but a new op
    // arriving behind it must still be held until the bus frees up.
    logic w_stall_idle;
    logic w_stall_busy;
    logic w_stall_drain;

    assign w_stall_idle  = (state_q == S_IDLE) && w_op && !w_misalign;
    assign w_stall_busy  = ((state_q == S_REQ) || (state_q == S_WAIT)) && !discard_q;
    assign w_stall_drain = (state_q == S_WAIT) && discard_q && w_op;

    assign mbus.stall      = resetn && !mbus.flush &&
                             (w_stall_idle || w_stall_busy || w_stall_drain);
    assign mbus.addr_err   = resetn && (state_q == S_IDLE) && w_op &&
                             !mbus.flush && w_misalign;
    assign mbus.resp_valid = resp_valid_q && !mbus.flush;
    assign mbus.resp_rdata = resp_rdata_q;
    assign mbus.data_req   = data_req_q;
    assign mbus.data_wr    = data_wr_q;
    assign mbus.data_size  = data_size_q;
    assign mbus.data_addr  = data_addr_q;
    assign mbus.data_wdata = data_wdata_q;
    assign mbus.data_wstrb = data_wstrb_q;

endmodule

`default_nettype wire
